icache_refill_bridge: RTL and testbench

Memory-side responder for the L1 instruction cache refill request (`icache_mem_req` / `mem_icache_addrOK` / `mem_icache_dataOK`). It accepts one line-refill request at a time, issues one AXI4 INCR read burst for the whole line, and collects the beats into a line buffer. When the line is complete it returns it to the Icache in a single `dataOK` cycle. It sits between the Icache FSM and the AXI read interconnect.

---
 rtl/icache_refill_bridge.sv | 136 +++++++++++++
 tb/tb_icache_refill_bridge.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill_bridge.sv
// Icache line-refill responder: accepts one refill request, issues a single AXI4
// INCR read burst for the whole line, and returns the assembled line in one dataOK cycle.
module icache_refill_bridge #(
  parameter int unsigned offset_width = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  // Icache side
  input  logic                                icache_mem_req,
  input  logic [1:0]                          icache_mem_size,
  input  logic [31:0]                         icache_mem_addr,
  output logic                                mem_icache_addrOK,
  output logic                                mem_icache_dataOK,
  output logic [32*(2**offset_width)-1:0]     mem_icache_data,
  output logic                                mem_icache_err,
  // AXI4 AR channel
  output logic [31:0]                         araddr,
  output logic [7:0]                          arlen,
  output logic [2:0]                          arsize,
  output logic [1:0]                          arburst,
  output logic                                arvalid,
  input  logic                                arready,
  // AXI4 R channel
  input  logic [31:0]                         rdata,
  input  logic [1:0]                          rresp,
  input  logic                                rlast,
  input  logic                                rvalid,
  output logic                                rready
);

  localparam int unsigned WORDS = 2 ** offset_width;
  localparam logic [offset_width-1:0] LAST_BEAT = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [31:0]             araddr_q, araddr_d;
  logic [offset_width-1:0] beat_q, beat_d;
  logic                    err_q, err_d;
  logic                    beat_we;
  logic [31:0]             line_q [WORDS];

  always_comb begin
    state_d           = state_q;
    araddr_d          = araddr_q;
    beat_d            = beat_q;
    err_d             = err_q;
    beat_we           = 1'b0;
    mem_icache_addrOK = 1'b0;
    mem_icache_dataOK = 1'b0;
    mem_icache_err    = 1'b0;
    arvalid           = 1'b0;
    rready            = 1'b0;

    case (state_q)
      S_IDLE: begin
        mem_icache_addrOK = icache_mem_req;
        if (icache_mem_req) begin
          araddr_d = {icache_mem_addr[31:offset_width+2], {(offset_width+2){1'b0}}};
          beat_d   = '0;
          // Illegal transfer sizes still fetch a full line but report an error.
          err_d    = (icache_mem_size != 2'd2);
          state_d  = S_AR;
        end
      end
      S_AR: begin
        arvalid = 1'b1;
        if (arready) begin
          state_d = S_R;
        end
      end
      S_R: begin
        rready = 1'b1;
        if (rvalid) begin
          beat_we = 1'b1;
          beat_d  = beat_q + 1'b1;
          if ((rresp != 2'b00) || (rlast != (beat_q == LAST_BEAT))) begin
            err_d = 1'b1;
          end
          // The beat count alone ends the burst; rlast only feeds the error flag.
          if (beat_q == LAST_BEAT) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        mem_icache_dataOK = 1'b1;
        mem_icache_err    = err_q;
        state_d           = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      araddr_q <= '0;
      beat_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      araddr_q <= araddr_d;
      beat_q   <= beat_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < WORDS; i++) begin
        line_q[i] <= '0;
      end
    end else if (beat_we) begin
      line_q[beat_q] <= rdata;
    end
  end

  always_comb begin
    mem_icache_data = '0;
    for (int unsigned i = 0; i < WORDS; i++) begin
      mem_icache_data[32*i +: 32] = line_q[i];
    end
  end

  assign araddr  = araddr_q;
  assign arlen   = 8'(WORDS - 1);
  assign arsize  = 3'b010;
  assign arburst = 2'b01;

endmodule

// File: tb/tb_icache_refill_bridge.sv
module tb_icache_refill_bridge;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req = 1'b0;
  logic [1:0]   mem_size = 2'd2;
  logic [31:0]  mem_addr = '0;
  logic         addr_ok, data_ok, mem_err;
  logic [127:0] mem_data;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid, rready;
  logic         arready = 1'b0;
  logic [31:0]  rdata = '0;
  logic [1:0]   rresp = '0;
  logic         rlast = 1'b0;
  logic         rvalid = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [31:0]  w    [4];
  logic [1:0]   resp [4];
  logic         last [4];
  logic [127:0] prev_line = '0;

  always #5 clk = ~clk;

  icache_refill_bridge #(.offset_width(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .icache_mem_req    (req),
    .icache_mem_size   (mem_size),
    .icache_mem_addr   (mem_addr),
    .mem_icache_addrOK (addr_ok),
    .mem_icache_dataOK (data_ok),
    .mem_icache_data   (mem_data),
    .mem_icache_err    (mem_err),
    .araddr            (araddr),
    .arlen             (arlen),
    .arsize            (arsize),
    .arburst           (arburst),
    .arvalid           (arvalid),
    .arready           (arready),
    .rdata             (rdata),
    .rresp             (rresp),
    .rlast             (rlast),
    .rvalid            (rvalid),
    .rready            (rready)
  );

  task automatic set_beats(input logic [31:0] b0, input logic [31:0] b1,
                           input logic [31:0] b2, input logic [31:0] b3);
    w[0] = b0; w[1] = b1; w[2] = b2; w[3] = b3;
    for (int i = 0; i < 4; i++) begin
      resp[i] = 2'b00;
      last[i] = (i == 3);
    end
  endtask

  task automatic refill(input logic [31:0] addr, input logic [1:0] size,
                        input int ar_stall, input int gap, input bit noise);
    logic [127:0] exp_line;
    logic [31:0]  base;
    logic         exp_err;
    base    = addr & 32'hFFFF_FFF0;
    exp_err = (size != 2'd2);
    for (int i = 0; i < 4; i++) begin
      exp_line[32*i +: 32] = w[i];
      if (resp[i] != 2'b00 || last[i] != (i == 3)) exp_err = 1'b1;
    end

    req = 1'b1; mem_addr = addr; mem_size = size;
    rvalid = noise ? 1'($urandom) : 1'b0; rdata = $urandom;
    #1;
    checks++;
    if (addr_ok !== 1'b1) begin errors++; $error("FAIL addrOK: observed=%0h expected=1", addr_ok); end
    checks++;
    if (mem_data !== prev_line) begin errors++; $error("FAIL idle_hold: observed=%0h expected=%0h", mem_data, prev_line); end
    @(negedge clk);
    req = 1'b0; mem_addr = $urandom; mem_size = 2'($urandom);

    for (int s = 0; s < ar_stall; s++) begin
      arready = 1'b0;
      rvalid = noise ? 1'($urandom) : 1'b0; rdata = $urandom;
      #1;
      checks++;
      if (arvalid !== 1'b1) begin errors++; $error("FAIL arvalid_stall: observed=%0h expected=1", arvalid); end
      checks++;
      if (araddr !== base) begin errors++; $error("FAIL araddr_stall: observed=%0h expected=%0h", araddr, base); end
      checks++;
      if (rready !== 1'b0) begin errors++; $error("FAIL rready_ar: observed=%0h expected=0", rready); end
      @(negedge clk);
    end
    arready = 1'b1;
    rvalid = noise ? 1'($urandom) : 1'b0; rdata = $urandom;
    #1;
    checks++;
    if (arvalid !== 1'b1) begin errors++; $error("FAIL arvalid: observed=%0h expected=1", arvalid); end
    checks++;
    if (araddr !== base) begin errors++; $error("FAIL araddr: observed=%0h expected=%0h", araddr, base); end
    checks++;
    if (arlen !== 8'd3) begin errors++; $error("FAIL arlen: observed=%0h expected=3", arlen); end
    checks++;
    if (arsize !== 3'b010) begin errors++; $error("FAIL arsize: observed=%0h expected=2", arsize); end
    checks++;
    if (arburst !== 2'b01) begin errors++; $error("FAIL arburst: observed=%0h expected=1", arburst); end
    checks++;
    if (mem_data !== prev_line) begin errors++; $error("FAIL ar_hold: observed=%0h expected=%0h", mem_data, prev_line); end
    @(negedge clk);
    arready = 1'b0;

    for (int b = 0; b < 4; b++) begin
      if (b > 0) begin
        for (int g = 0; g < gap; g++) begin
          rvalid = 1'b0; rdata = $urandom;
          #1;
          checks++;
          if (rready !== 1'b1) begin errors++; $error("FAIL rready_gap: observed=%0h expected=1", rready); end
          checks++;
          if (data_ok !== 1'b0) begin errors++; $error("FAIL dataOK_gap: observed=%0h expected=0", data_ok); end
          @(negedge clk);
        end
      end
      rvalid = 1'b1; rdata = w[b]; rresp = resp[b]; rlast = last[b];
      #1;
      checks++;
      if (rready !== 1'b1) begin errors++; $error("FAIL rready_beat: observed=%0h expected=1", rready); end
      checks++;
      if (data_ok !== 1'b0) begin errors++; $error("FAIL dataOK_beat: observed=%0h expected=0", data_ok); end
      @(negedge clk);
    end
    rvalid = 1'b0; rresp = 2'b00; rlast = 1'b0;
    #1;
    checks++;
    if (data_ok !== 1'b1) begin errors++; $error("FAIL dataOK: observed=%0h expected=1", data_ok); end
    checks++;
    if (mem_data !== exp_line) begin errors++; $error("FAIL line: observed=%0h expected=%0h", mem_data, exp_line); end
    checks++;
    if (mem_err !== exp_err) begin errors++; $error("FAIL err: observed=%0h expected=%0h", mem_err, exp_err); end
    checks++;
    if (rready !== 1'b0) begin errors++; $error("FAIL rready_done: observed=%0h expected=0", rready); end
    checks++;
    if (addr_ok !== 1'b0) begin errors++; $error("FAIL addrOK_done: observed=%0h expected=0", addr_ok); end
    prev_line = exp_line;
  endtask

  task automatic post_done();
    @(negedge clk);
    #1;
    checks++;
    if (data_ok !== 1'b0) begin errors++; $error("FAIL dataOK_pulse: observed=%0h expected=0", data_ok); end
    checks++;
    if (mem_err !== 1'b0) begin errors++; $error("FAIL err_pulse: observed=%0h expected=0", mem_err); end
    checks++;
    if (mem_data !== prev_line) begin errors++; $error("FAIL line_hold: observed=%0h expected=%0h", mem_data, prev_line); end
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (arvalid !== 1'b0) begin errors++; $error("FAIL rst_arvalid: observed=%0h expected=0", arvalid); end
    checks++;
    if (rready !== 1'b0) begin errors++; $error("FAIL rst_rready: observed=%0h expected=0", rready); end
    checks++;
    if (addr_ok !== 1'b0) begin errors++; $error("FAIL rst_addrOK: observed=%0h expected=0", addr_ok); end
    checks++;
    if (data_ok !== 1'b0) begin errors++; $error("FAIL rst_dataOK: observed=%0h expected=0", data_ok); end
    checks++;
    if (mem_err !== 1'b0) begin errors++; $error("FAIL rst_err: observed=%0h expected=0", mem_err); end
    checks++;
    if (araddr !== 32'h0) begin errors++; $error("FAIL rst_araddr: observed=%0h expected=0", araddr); end
    checks++;
    if (mem_data !== 128'h0) begin errors++; $error("FAIL rst_data: observed=%0h expected=0", mem_data); end
    rst = 1'b0;
    @(negedge clk);

    set_beats(32'hA0, 32'hA1, 32'hA2, 32'hA3);
    refill(32'h1000_0034, 2'd2, 0, 0, 1'b0);
    post_done();

    set_beats(32'hB0B0_0000, 32'hB1B1_1111, 32'hB2B2_2222, 32'hB3B3_3333);
    refill(32'h0000_5678, 2'd2, 3, 1, 1'b0);
    post_done();

    set_beats(32'hC0, 32'hC1, 32'hC2, 32'hC3);
    resp[1] = 2'b10;
    refill(32'h4000_0008, 2'd2, 0, 0, 1'b0);
    post_done();

    set_beats(32'hD0, 32'hD1, 32'hD2, 32'hD3);
    last[2] = 1'b1;
    refill(32'h4000_0010, 2'd2, 1, 0, 1'b0);
    post_done();

    set_beats(32'hE0, 32'hE1, 32'hE2, 32'hE3);
    refill(32'h5000_001C, 2'd0, 0, 0, 1'b0);
    post_done();

    req = 1'b1; mem_addr = 32'h6000_0040; mem_size = 2'd2;
    @(negedge clk);
    req = 1'b0; arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      rvalid = 1'b1; rdata = 32'hF0 + b; rlast = 1'b0;
      @(negedge clk);
    end
    rvalid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (arvalid !== 1'b0) begin errors++; $error("FAIL mid_rst_arvalid: observed=%0h expected=0", arvalid); end
    checks++;
    if (rready !== 1'b0) begin errors++; $error("FAIL mid_rst_rready: observed=%0h expected=0", rready); end
    checks++;
    if (data_ok !== 1'b0) begin errors++; $error("FAIL mid_rst_dataOK: observed=%0h expected=0", data_ok); end
    checks++;
    if (mem_err !== 1'b0) begin errors++; $error("FAIL mid_rst_err: observed=%0h expected=0", mem_err); end
    checks++;
    if (araddr !== 32'h0) begin errors++; $error("FAIL mid_rst_araddr: observed=%0h expected=0", araddr); end
    checks++;
    if (mem_data !== 128'h0) begin errors++; $error("FAIL mid_rst_data: observed=%0h expected=0", mem_data); end
    checks++;
    if (addr_ok !== 1'b0) begin errors++; $error("FAIL mid_rst_addrOK: observed=%0h expected=0", addr_ok); end
    prev_line = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (data_ok !== 1'b0) begin errors++; $error("FAIL mid_rst_quiet: observed=%0h expected=0", data_ok); end
    end
    @(negedge clk);
    set_beats(32'h2000_AAAA, 32'h2000_BBBB, 32'h2000_CCCC, 32'h2000_DDDD);
    refill(32'h2000_0000, 2'd2, 0, 0, 1'b0);
    post_done();

    set_beats(32'h11, 32'h22, 32'h33, 32'h44);
    refill(32'h3000_0020, 2'd2, 0, 0, 1'b0);
    @(negedge clk);
    set_beats(32'h55, 32'h66, 32'h77, 32'h88);
    refill(32'h3000_0030, 2'd2, 2, 0, 1'b0);
    post_done();

    for (int t = 0; t < 24; t++) begin
      logic [1:0] sz;
      set_beats($urandom, $urandom, $urandom, $urandom);
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 7) == 0) resp[i] = 2'($urandom_range(1, 3));
        if ($urandom_range(0, 7) == 0) last[i] = ~last[i];
      end
      sz = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'd2;
      refill($urandom, sz, $urandom_range(0, 2), $urandom_range(0, 2), 1'b1);
      if ($urandom_range(0, 1) == 1) begin
        post_done();
      end else begin
        @(negedge clk);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
